exm_stack_unit: RTL
===================

# exm_stack_unit

Stack engine of the execute/memory (EXM) stage. It consumes the stack and PC-transfer controls registered by the decode→EXM pipeline buffer and owns the stack pointer (SP). It sequences 16-bit data-memory accesses for PUSH/POP and for the two-word 32-bit PC transfers used by CALL/RET/interrupts. It stalls upstream stages while a multi-cycle transfer is in progress.

## Interface
- ADDR_WIDTH, 11: data-memory word-address width; SP width.
- SP_RESET, 2**ADDR_WIDTH-1: SP value after reset (top of memory).

- i_clk  in  1  clock; all state changes on the rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_valid  in  1  instruction present in EXM this cycle (buffer not bubbled).
- i_stack_operation  in  1  PUSH/POP instruction.
- i_stack_function  in  1  1 = push, 0 = pop (only meaningful with i_stack_operation).
- i_push_pc  in  1  push 32-bit PC (CALL/INT).
- i_pop_pc  in  1  pop 32-bit PC (RET/RTI).
- i_data  in  16  push data (register data1).
- i_pc  in  32  PC value to push.
- i_mem_rdata  in  16  data-memory read data; valid the cycle after o_mem_read.
- o_mem_addr  out  ADDR_WIDTH  memory word address.
- o_mem_wdata  out  16  memory write data.
- o_mem_read  out  1  read strobe.
- o_mem_write  out  1  write strobe.
- o_stall  out  1  hold fetch/decode and the decode→EXM buffer (drives its enable low).
- o_pop_valid  out  1  one-cycle pulse; o_pop_data valid.
- o_pop_data  out  16  popped word, routed to write-back.
- o_pc_load  out  1  one-cycle pulse; o_pc_out valid.
- o_pc_out  out  32  popped PC, routed to the PC mux.
- o_sp  out  ADDR_WIDTH  current SP.

## Operation
- Stack model:
  - Stack grows downward; SP points at the next free word.
  - Push writes M[SP], then SP−1.
  - Pop increments SP, then reads M[SP].
- SP arithmetic is modulo 2^ADDR_WIDTH. Wrap is silent; there is no overflow or underflow flag.
- Command decode applies only in IDLE and only when i_valid=1. Priority, highest first:
  1. i_pop_pc
  2. i_push_pc
  3. i_stack_operation
- i_valid=0, or no command asserted: no memory access, SP unchanged.
- FSM states: IDLE, POP_WAIT, PUSH_LO, POPPC_HI, POPPC_DONE.
- Transitions:
  - IDLE→POP_WAIT on a pop.
  - IDLE→PUSH_LO on push_pc.
  - IDLE→POPPC_HI on pop_pc.
  - POPPC_HI→POPPC_DONE.
  - POP_WAIT, PUSH_LO and POPPC_DONE return to IDLE.
  - Plain push stays in IDLE.
- In non-IDLE states all command inputs are ignored: upstream is stalled and still presents the same instruction.
- i_pc[15:0] is latched at push_pc issue.
- The low half of the PC is latched from i_mem_rdata in POPPC_HI.
- Word order:
  - push_pc writes PC[31:16] at SP, then PC[15:0] at SP−1.
  - pop_pc reads the low half first (SP+1), then the high half (SP+2).
- Reset values:
  - FSM returns to IDLE and SP = SP_RESET.
  - All other outputs are 0.
  - Reset in any state aborts the transfer: no o_pop_valid or o_pc_load pulse follows.

## Timing
- All memory outputs and o_stall are combinational from state, SP and inputs. SP updates on the clock edge ending the cycle.
- o_pop_data and o_pc_out are 0 whenever their valid pulse is low.
- In each sequence below, T is the issue cycle in IDLE.
- PUSH (1 cycle):
  - T: write=1, addr=SP, wdata=i_data, stall=0; SP−1.
- POP (2 cycles):
  - T: read=1, addr=SP+1, stall=1; SP+1.
  - T+1: pop_valid=1, pop_data=i_mem_rdata, stall=0.
- PUSH_PC (2 cycles):
  - T: write=1, addr=SP, wdata=i_pc[31:16], stall=1; SP−1.
  - T+1: write=1, addr=SP, wdata=latched PC low, stall=0; SP−1.
- POP_PC (3 cycles):
  - T: read=1, addr=SP+1, stall=1; SP+1.
  - T+1: read=1, addr=SP+1, stall=1, capture low; SP+1.
  - T+2: pc_load=1, pc_out={i_mem_rdata, low}, stall=0.
- At most one memory strobe per cycle; o_mem_read and o_mem_write are never both 1.
- o_stall is never asserted in the final cycle of a sequence, so the next instruction enters EXM at the following edge.

## Test plan
- Reset: assert i_reset 2 cycles → o_sp=0x7FF; every other output 0; FSM in IDLE.
- PUSH then POP:
  - PUSH 0xBEEF → write addr 0x7FF, data 0xBEEF, stall 0; o_sp=0x7FE.
  - POP → read addr 0x7FF with stall 1; next cycle pop_valid=1, pop_data=0xBEEF; o_sp=0x7FF.
- PC round trip:
  - push_pc with i_pc=0x0001_2345 → writes 0x7FF←0x0001 (stall 1), then 0x7FE←0x2345 (stall 0); o_sp=0x7FD.
  - pop_pc → reads 0x7FE, then 0x7FF; third cycle pc_load=1, pc_out=0x0001_2345; o_sp=0x7FF.
- Wrap-around:
  - POP at SP=0x7FF → read addr 0x000; o_sp=0x000.
  - PUSH 0x1234 → write addr 0x000; o_sp=0x7FF.
- Reset mid-operation: assert i_reset in the POPPC_DONE cycle (T+2) → next cycle FSM IDLE, o_sp=0x7FF, no further pc_load pulse.
- Priority and qualification:
  - i_push_pc and i_stack_operation both high → PC push only (two writes, SP−2).
  - Any command with i_valid=0 → no strobes and SP unchanged.

Source files
------------

// File: rtl/exm_stack_unit.sv
// EXM stack engine: owns SP and sequences PUSH/POP and 2-word PC push/pop to data memory.
// PUSH 1 cycle, POP/PUSH_PC 2 cycles, POP_PC 3 cycles; o_stall holds upstream until the last cycle.
module exm_stack_unit #(
  parameter int                    ADDR_WIDTH = 11,
  parameter logic [ADDR_WIDTH-1:0] SP_RESET   = {ADDR_WIDTH{1'b1}}
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_valid,
  input  logic                  i_stack_operation,
  input  logic                  i_stack_function,
  input  logic                  i_push_pc,
  input  logic                  i_pop_pc,
  input  logic [15:0]           i_data,
  input  logic [31:0]           i_pc,
  input  logic [15:0]           i_mem_rdata,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [15:0]           o_mem_wdata,
  output logic                  o_mem_read,
  output logic                  o_mem_write,
  output logic                  o_stall,
  output logic                  o_pop_valid,
  output logic [15:0]           o_pop_data,
  output logic                  o_pc_load,
  output logic [31:0]           o_pc_out,
  output logic [ADDR_WIDTH-1:0] o_sp
);

  typedef enum logic [2:0] {
    IDLE,
    POP_WAIT,
    PUSH_LO,
    POPPC_HI,
    POPPC_DONE
  } state_t;

  localparam logic [ADDR_WIDTH-1:0] SP_ONE = ADDR_WIDTH'(1);

  state_t          state_q, state_d;
  logic [ADDR_WIDTH-1:0] sp_q, sp_d;
  // Shared holding register: PC low half on push_pc, popped low word on pop_pc.
  logic [15:0]     pc_lo_q, pc_lo_d;

  logic [ADDR_WIDTH-1:0] sp_inc;
  logic [ADDR_WIDTH-1:0] sp_dec;

  assign sp_inc = sp_q + SP_ONE;
  assign sp_dec = sp_q - SP_ONE;
  assign o_sp   = sp_q;

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    pc_lo_d     = pc_lo_q;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_mem_read  = 1'b0;
    o_mem_write = 1'b0;
    o_stall     = 1'b0;
    o_pop_valid = 1'b0;
    o_pop_data  = '0;
    o_pc_load   = 1'b0;
    o_pc_out    = '0;

    unique case (state_q)
      IDLE: begin
        if (i_valid) begin
          if (i_pop_pc) begin
            o_mem_read = 1'b1;
            o_mem_addr = sp_inc;
            o_stall    = 1'b1;
            sp_d       = sp_inc;
            state_d    = POPPC_HI;
          end else if (i_push_pc) begin
            o_mem_write = 1'b1;
            o_mem_addr  = sp_q;
            o_mem_wdata = i_pc[31:16];
            o_stall     = 1'b1;
            sp_d        = sp_dec;
            pc_lo_d     = i_pc[15:0];
            state_d     = PUSH_LO;
          end else if (i_stack_operation) begin
            if (i_stack_function) begin
              o_mem_write = 1'b1;
              o_mem_addr  = sp_q;
              o_mem_wdata = i_data;
              sp_d        = sp_dec;
            end else begin
              o_mem_read = 1'b1;
              o_mem_addr = sp_inc;
              o_stall    = 1'b1;
              sp_d       = sp_inc;
              state_d    = POP_WAIT;
            end
          end
        end
      end
      POP_WAIT: begin
        o_pop_valid = 1'b1;
        o_pop_data  = i_mem_rdata;
        state_d     = IDLE;
      end
      PUSH_LO: begin
        o_mem_write = 1'b1;
        o_mem_addr  = sp_q;
        o_mem_wdata = pc_lo_q;
        sp_d        = sp_dec;
        state_d     = IDLE;
      end
      POPPC_HI: begin
        o_mem_read = 1'b1;
        o_mem_addr = sp_inc;
        o_stall    = 1'b1;
        sp_d       = sp_inc;
        pc_lo_d    = i_mem_rdata;
        state_d    = POPPC_DONE;
      end
      POPPC_DONE: begin
        o_pc_load = 1'b1;
        o_pc_out  = {i_mem_rdata, pc_lo_q};
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Reset overrides everything, including a pulse that would have fired this cycle.
    if (i_reset) begin
      state_d     = IDLE;
      sp_d        = SP_RESET;
      pc_lo_d     = '0;
      o_mem_addr  = '0;
      o_mem_wdata = '0;
      o_mem_read  = 1'b0;
      o_mem_write = 1'b0;
      o_stall     = 1'b0;
      o_pop_valid = 1'b0;
      o_pop_data  = '0;
      o_pc_load   = 1'b0;
      o_pc_out    = '0;
    end
  end

  always_ff @(posedge i_clk) begin
    state_q <= state_d;
    sp_q    <= sp_d;
    pc_lo_q <= pc_lo_d;
  end

endmodule
